sobel_padder_ctrl: RTL and testbench

Sequencer between the grayscale FIFO and the padder FIFO in the sobel pipeline. On each start, it emits one padded frame of (WIDTH+2) x (HEIGHT+2) pixels in raster order into the padder FIFO. Border positions carry PAD_VALUE; interior positions carry grayscale pixels popped from the grayscale FIFO. The downstream sobel stage therefore always sees a full 3x3 neighbourhood, including at image edges.

---
 rtl/sobel_padder_ctrl.sv | 103 ++++++++++
 tb/tb_sobel_padder_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_padder_ctrl.sv
// Sobel padder sequencer: drains the grayscale FIFO into the padder FIFO,
// framing every image with a one-pixel PAD_VALUE border in raster order.
module sobel_padder_ctrl #(
    parameter int                WIDTH     = 720,
    parameter int                HEIGHT    = 540,
    parameter int                DWIDTH    = 8,
    parameter logic [DWIDTH-1:0] PAD_VALUE = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              fifo_in_rd_en,
    input  logic [DWIDTH-1:0] fifo_in_dout,
    input  logic              fifo_in_empty,
    output logic              fifo_out_wr_en,
    output logic [DWIDTH-1:0] fifo_out_din,
    input  logic              fifo_out_full,
    output logic              busy,
    output logic              done
);

    localparam int RW = $clog2(HEIGHT + 2);
    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT + 1);
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [RW-1:0] row;
    logic [RW-1:0] row_next;
    logic [CW-1:0] col;
    logic [CW-1:0] col_next;
    logic          border;

    assign border = (row == '0) || (row == ROW_LAST) ||
                    (col == '0) || (col == COL_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            row   <= '0;
            col   <= '0;
        end else begin
            state <= state_next;
            row   <= row_next;
            col   <= col_next;
        end
    end

    always_comb begin
        state_next     = state;
        row_next       = row;
        col_next       = col;
        busy           = 1'b0;
        done           = 1'b0;
        fifo_in_rd_en  = 1'b0;
        fifo_out_wr_en = 1'b0;
        fifo_out_din   = '0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    row_next   = '0;
                    col_next   = '0;
                end
            end
            RUN: begin
                busy = 1'b1;
                // Border pixels never wait on input; only a full output stalls them.
                fifo_out_wr_en = !fifo_out_full && (border || !fifo_in_empty);
                fifo_in_rd_en  = !fifo_out_full && !border && !fifo_in_empty;
                fifo_out_din   = border ? PAD_VALUE : fifo_in_dout;
                if (fifo_out_wr_en) begin
                    if (col == COL_LAST) begin
                        col_next = '0;
                        if (row == ROW_LAST) begin
                            row_next   = '0;
                            state_next = DONE;
                        end else begin
                            row_next = row + 1'b1;
                        end
                    end else begin
                        col_next = col + 1'b1;
                    end
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sobel_padder_ctrl.sv
// Randomized bench for sobel_padder_ctrl: a frame-position scoreboard checks
// every cycle, and one task per scenario checks the frame-level totals.
module tb_sobel_padder_ctrl;

    localparam int W     = 4;
    localparam int H     = 3;
    localparam int DW    = 8;
    localparam int TOTAL = (W + 2) * (H + 2);
    localparam int NPIX  = W * H;
    localparam logic [DW-1:0] PAD = 8'h00;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          rd_en;
    logic [DW-1:0] dout  = '0;
    logic          empty = 1'b1;
    logic          wr_en;
    logic [DW-1:0] din;
    logic          full  = 1'b0;
    logic          busy;
    logic          done;

    always #5 clock = ~clock;

    sobel_padder_ctrl #(
        .WIDTH    (W),
        .HEIGHT   (H),
        .DWIDTH   (DW),
        .PAD_VALUE(PAD)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .fifo_in_rd_en (rd_en),
        .fifo_in_dout  (dout),
        .fifo_in_empty (empty),
        .fifo_out_wr_en(wr_en),
        .fifo_out_din  (din),
        .fifo_out_full (full),
        .busy          (busy),
        .done          (done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: phase 0=idle 1=run 2=done, k = linear padded position
    logic [DW-1:0] in_q[$];
    logic [DW-1:0] out_log[$];
    int phase = 0;
    int k = 0;
    int writes = 0, pops = 0, busy_cycles = 0, dones = 0;

    always @(negedge clock) begin
        int r, c;
        logic bord, ebusy, edone, ewr, erd;
        logic [DW-1:0] edin;
        #1;
        empty = (in_q.size() == 0);
        dout  = empty ? '0 : in_q[0];
        #3;
        if (!reset) phase = 0;
        r     = k / (W + 2);
        c     = k % (W + 2);
        bord  = (r == 0) || (r == H + 1) || (c == 0) || (c == W + 1);
        ebusy = (phase == 1);
        edone = (phase == 2);
        ewr   = ebusy && !full && (bord || !empty);
        erd   = ewr && !bord;
        edin  = ebusy ? (bord ? PAD : dout) : '0;
        n_tests++;
        if ({busy, done, wr_en, rd_en, din} !== {ebusy, edone, ewr, erd, edin}) begin
            n_fail++;
            $display("FAIL cycle pos=%0d phase=%0d busy/done/wr/rd/din got %b%b%b%b %0d want %b%b%b%b %0d",
                     k, phase, busy, done, wr_en, rd_en, din,
                     ebusy, edone, ewr, erd, edin);
        end
        if (wr_en) begin
            writes++;
            out_log.push_back(din);
        end
        if (rd_en) pops++;
        if (busy) busy_cycles++;
        if (done) dones++;
        if (reset) begin
            case (phase)
                0: if (start) begin
                    phase = 1;
                    k = 0;
                end
                1: if (ewr) begin
                    if (erd) void'(in_q.pop_front());
                    k++;
                    if (k == TOTAL) phase = 2;
                end
                default: phase = 0;
            endcase
        end
    end

    task automatic clear_stats();
        writes = 0;
        pops = 0;
        busy_cycles = 0;
        dones = 0;
        out_log.delete();
    endtask

    task automatic fill(input int first, input int n);
        for (int i = 0; i < n; i++) in_q.push_back(DW'(first + i));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0 = dones;
        int i = 0;
        while (dones == d0 && i < budget) begin
            @(negedge clock);
            i++;
        end
        n_tests++;
        if (dones == d0) begin
            n_fail++;
            $display("FAIL %s timeout: no done within %0d cycles", name, budget);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        #2;
        start = 1'b1;
        reset = 1'b0;
        #1;
        n_tests++;
        if ({busy, done, wr_en, rd_en, din} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got %b want 0", {busy, done, wr_en, rd_en, din});
        end
        @(negedge clock);
        start = 1'b0;
        reset = 1'b1;
        clear_stats();
        repeat (20) @(negedge clock);
        n_tests++;
        if (writes !== 0 || pops !== 0 || busy_cycles !== 0) begin
            n_fail++;
            $display("FAIL reset_idle writes=%0d pops=%0d busy=%0d want 0", writes, pops, busy_cycles);
        end
    endtask

    task automatic test_normal_frame();
        clear_stats();
        fill(1, NPIX);
        pulse_start();
        wait_done("normal", 200);
        n_tests++;
        if (writes !== TOTAL || pops !== NPIX || busy_cycles !== TOTAL || dones !== 1) begin
            n_fail++;
            $display("FAIL normal_totals w=%0d p=%0d busy=%0d d=%0d want %0d %0d %0d 1",
                     writes, pops, busy_cycles, dones, TOTAL, NPIX, TOTAL);
        end
        n_tests++;
        if (out_log.size() != TOTAL || out_log[7] !== 8'd1 || out_log[22] !== 8'd12) begin
            n_fail++;
            $display("FAIL normal_values size=%0d want %0d (pos7=1 pos22=12)", out_log.size(), TOTAL);
        end
    endtask

    task automatic test_empty_input();
        clear_stats();
        pulse_start();
        repeat (12) @(negedge clock);
        n_tests++;
        if (writes !== W + 3 || pops !== 0) begin
            n_fail++;
            $display("FAIL empty_stall writes=%0d pops=%0d want %0d 0", writes, pops, W + 3);
        end
        fill(1, 1);
        @(negedge clock);
        n_tests++;
        if (writes !== W + 4 || pops !== 1 || out_log[W + 3] !== 8'd1) begin
            n_fail++;
            $display("FAIL empty_resume writes=%0d pops=%0d want %0d 1", writes, pops, W + 4);
        end
        fill(2, NPIX - 1);
        wait_done("empty", 200);
        n_tests++;
        if (writes !== TOTAL || pops !== NPIX) begin
            n_fail++;
            $display("FAIL empty_totals w=%0d p=%0d want %0d %0d", writes, pops, TOTAL, NPIX);
        end
    endtask

    task automatic test_backpressure();
        int w0;
        int i = 0;
        clear_stats();
        fill(1, NPIX);
        pulse_start();
        while (!(phase == 1 && k == 2 * (W + 2) + 2) && i < 100) begin
            @(negedge clock);
            i++;
        end
        full = 1'b1;
        w0 = writes;
        repeat (5) @(negedge clock);
        n_tests++;
        if (writes !== w0 || pops !== 5) begin
            n_fail++;
            $display("FAIL bp_hold writes=%0d pops=%0d want %0d 5", writes, pops, w0);
        end
        full = 1'b0;
        @(negedge clock);
        n_tests++;
        if (writes !== w0 + 1 || out_log[out_log.size() - 1] !== 8'd6) begin
            n_fail++;
            $display("FAIL bp_release writes=%0d last=%0d want %0d 6",
                     writes, out_log[out_log.size() - 1], w0 + 1);
        end
        wait_done("bp", 200);
        n_tests++;
        if (writes !== TOTAL || pops !== NPIX) begin
            n_fail++;
            $display("FAIL bp_totals w=%0d p=%0d want %0d %0d", writes, pops, TOTAL, NPIX);
        end
    endtask

    task automatic test_back_to_back();
        int i = 0;
        clear_stats();
        fill(1, 2 * NPIX);
        pulse_start();
        repeat (5) @(negedge clock);
        pulse_start();
        while (phase != 2 && i < 200) begin
            @(negedge clock);
            i++;
        end
        // start held through DONE and the first IDLE cycle
        start = 1'b1;
        @(negedge clock);
        @(negedge clock);
        start = 1'b0;
        wait_done("b2b", 200);
        n_tests++;
        if (dones !== 2 || writes !== 2 * TOTAL || pops !== 2 * NPIX || in_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_totals d=%0d w=%0d p=%0d left=%0d want 2 %0d %0d 0",
                     dones, writes, pops, in_q.size(), 2 * TOTAL, 2 * NPIX);
        end
        n_tests++;
        if (out_log[TOTAL + W + 3] !== 8'd13) begin
            n_fail++;
            $display("FAIL b2b_second_first got %0d want 13", out_log[TOTAL + W + 3]);
        end
    endtask

    task automatic test_reset_mid_frame();
        int i = 0;
        clear_stats();
        fill(1, NPIX);
        pulse_start();
        while (writes < 15 && i < 100) begin
            @(negedge clock);
            i++;
        end
        reset = 1'b0;
        #2;
        n_tests++;
        if ({busy, done, wr_en, rd_en, din} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs got %b want 0", {busy, done, wr_en, rd_en, din});
        end
        in_q.delete();
        @(negedge clock);
        reset = 1'b1;
        clear_stats();
        fill(1, NPIX);
        pulse_start();
        wait_done("midreset", 200);
        n_tests++;
        if (writes !== TOTAL || out_log[0] !== PAD || out_log[W + 3] !== 8'd1) begin
            n_fail++;
            $display("FAIL midreset_restart w=%0d first=%0d want %0d %0d",
                     writes, out_log[0], TOTAL, PAD);
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 4; f++) begin
            int pushed = 0;
            int cyc = 0;
            int d0;
            clear_stats();
            start = 1'b1;
            @(negedge clock);
            start = 1'b0;
            d0 = dones;
            while (dones == d0 && cyc < 2000) begin
                full = ($urandom_range(0, 3) == 0);
                if (pushed < NPIX && $urandom_range(0, 1) == 1) begin
                    in_q.push_back(DW'($urandom));
                    pushed++;
                end
                @(negedge clock);
                cyc++;
            end
            full = 1'b0;
            n_tests++;
            if (dones == d0 || writes !== TOTAL || pops !== NPIX) begin
                n_fail++;
                $display("FAIL random_frame%0d d=%0d w=%0d p=%0d want 1 %0d %0d",
                         f, dones - d0, writes, pops, TOTAL, NPIX);
            end
            @(negedge clock);
        end
    endtask

    initial begin
        test_reset();
        test_normal_frame();
        test_empty_input();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        repeat (3) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
